alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request a new operation; sampled only in IDLE.
REQ-004 op  input  3  opcode {Op2,Op1,Op0}: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal.
REQ-005 a  input  32  operand A, captured on accepted start.
REQ-006 b  input  32  operand B, captured on accepted start.
REQ-007 busy  output  1  high in RUN and DONE states.
REQ-008 done  output  1  one-cycle pulse: result, cout, zero and err valid.
REQ-009 result  output  32  operation result, held until the next accepted start.
REQ-010 cout  output  1  final carry for ADD/SUB; 0 for all other opcodes.
REQ-011 zero  output  1  high when result == 0, updated with done.
REQ-012 err  output  1  high with done for illegal opcode; cleared on next accepted start.

Function
REQ-013 The block SHALL compute 32-bit operations bit-serially with one 1-bit ALU slice, LSB first, one bit per clock.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start with legal op, IDLE->DONE on start with illegal op, RUN->DONE after bit 31, DONE->IDLE unconditionally.
REQ-015 Accepted start SHALL capture a, b, op into shift registers, clear bit counter to 0, clear err.
REQ-016 Carry register SHALL load 1 for SUB/SLT and 0 otherwise on accepted start, feed slice Cin, and load slice Cout each RUN cycle.
REQ-017 Slice SHALL receive Ai=a_sh[0], Bi=b_sh[0], Less=0; slice opcode SHALL equal op except SLT, which drives 110 (SUB).
REQ-018 Each RUN cycle SHALL shift a_sh, b_sh right by one and shift slice Ri into result MSB (result shifts right); counter increments 0..31 with no wrap past 31.
REQ-019 For SLT, entry into DONE SHALL replace result with {31'b0, difference bit 31} (no overflow correction), cout forced 0.
REQ-020 Latency: start accepted at edge k; done high in cycle after edge k+33 for legal ops, after edge k+1 for illegal ops.
REQ-021 Illegal op SHALL give result 0, cout 0, zero 1, err 1.
REQ-022 start while busy SHALL be ignored, no queuing; start in the DONE cycle SHALL be ignored.
REQ-023 result, cout, zero SHALL not change during RUN visible outputs: intermediate shifting uses an internal register, copied to result on entry to DONE.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and busy=0, done=0, result=0, cout=0, zero=0, err=0, counter=0, carry=0.
REQ-025 Reset mid-RUN SHALL abort the operation with no done pulse; first start after release SHALL execute normally.

Structure
REQ-026 Shared package alu_pkg SHALL hold WIDTH=32, opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT), and the FSM state type.
REQ-027 The existing 1-bit slice alu SHALL be instantiated exactly once as the only sub-module; no parallel adder allowed.

Verification
REQ-028 ADD a=0xFFFFFFFF, b=0x00000001 -> done at edge k+33, result 0x00000000, cout 1, zero 1.
REQ-029 SUB a=5, b=7 -> result 0xFFFFFFFE, cout 0, zero 0; SUB a=7, b=7 -> result 0, cout 1, zero 1.
REQ-030 AND a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000; OR same operands -> 0xFFF0FFF0; cout 0.
REQ-031 SLT a=0xFFFFFFFE, b=1 -> result 0x00000001; SLT a=4, b=2 -> result 0x00000000.
REQ-032 Illegal op 011 -> done one cycle after start, err 1, result 0; start pulsed at bit 10 of an ADD ignored; rst_n low at bit 10 -> busy 0, no done, next ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the bit-serial ALU controller.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu.sv
// One-bit ALU slice: op[2] inverts B, op[1:0] selects AND/OR/SUM/LESS.
module alu
    import alu_pkg::*;
(
    input  logic            ai_i,
    input  logic            bi_i,
    input  logic            cin_i,
    input  logic            less_i,
    input  logic [OP_W-1:0] op_i,
    output logic            ri_o,
    output logic            cout_o
);

    logic b_eff;
    logic sum;

    assign b_eff  = bi_i ^ op_i[2];
    assign sum    = ai_i ^ b_eff ^ cin_i;
    assign cout_o = (ai_i & b_eff) | (ai_i & cin_i) | (b_eff & cin_i);

    always_comb begin
        ri_o = 1'b0;
        case (op_i[1:0])
            2'b00:   ri_o = ai_i & b_eff;
            2'b01:   ri_o = ai_i | b_eff;
            2'b10:   ri_o = sum;
            default: ri_o = less_i;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial 32-bit ALU: a single 1-bit slice walks the operands LSB first,
// one bit per clock, under a three-state controller.
module alu_serial_ctrl
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             err
);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [OP_W-1:0]  op_q,     op_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             zero_q,   zero_d;
    logic             err_q,    err_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [OP_W-1:0]  slice_op;
    logic             slice_r;
    logic             slice_cout;

    // SLT runs the slice as a subtract and keeps only the sign bit afterwards
    assign slice_op = (op_q == OP_SLT) ? OP_SUB : op_q;

    alu u_slice (
        .ai_i   (a_sh_q[0]),
        .bi_i   (b_sh_q[0]),
        .cin_i  (carry_q),
        .less_i (1'b0),
        .op_i   (slice_op),
        .ri_o   (slice_r),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    op_d     = op;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    carry_d  = (op == OP_SUB) || (op == OP_SLT);
                    state_d  = op_legal(op) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {slice_r, res_sh_q[WIDTH-1:1]};
                carry_d  = slice_cout;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Visible outputs only change here, together with the done pulse
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_legal(op_q)) begin
                    result_d = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, res_sh_q[WIDTH-1]}
                                                : res_sh_q;
                    cout_d   = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? carry_q : 1'b0;
                    err_d    = 1'b0;
                end else begin
                    result_d = '0;
                    cout_d   = 1'b0;
                    err_d    = 1'b1;
                end
                zero_d = (result_d == '0);
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for the bit-serial ALU controller.
module tb_alu_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_serial_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Pulse start for one cycle; returns #1 after the accepting edge
    task automatic launch(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen, bounded by budget
    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (cout !== 1'b0)    begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
        n_checks++; if (zero !== 1'b0)    begin n_fail++; $display("FAIL reset_zero got %b want 0", zero); end
        n_checks++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        launch(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy got %b want 1", busy); end
        wait_done(100, lat);
        n_checks++; if (lat !== 33)           begin n_fail++; $display("FAIL add_latency got %0d want 33", lat); end
        n_checks++; if (result !== 32'h0)     begin n_fail++; $display("FAIL add_result got %h want 00000000", result); end
        n_checks++; if (cout !== 1'b1)        begin n_fail++; $display("FAIL add_cout got %b want 1", cout); end
        n_checks++; if (zero !== 1'b1)        begin n_fail++; $display("FAIL add_zero got %b want 1", zero); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL add_after got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_sub;
        int lat;
        launch(3'b110, 32'd5, 32'd7);
        wait_done(100, lat);
        n_checks++; if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub57_result got %h want fffffffe", result); end
        n_checks++; if (cout !== 1'b0 || zero !== 1'b0) begin
            n_fail++; $display("FAIL sub57_flags got cout=%b zero=%b want 0 0", cout, zero);
        end
        launch(3'b110, 32'd7, 32'd7);
        wait_done(100, lat);
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL sub77_result got %h want 0", result); end
        n_checks++; if (cout !== 1'b1 || zero !== 1'b1) begin
            n_fail++; $display("FAIL sub77_flags got cout=%b zero=%b want 1 1", cout, zero);
        end
    endtask

    task automatic test_logic;
        int lat;
        launch(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_done(100, lat);
        n_checks++; if (result !== 32'hF000_F000) begin n_fail++; $display("FAIL and_result got %h want f000f000", result); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL and_cout got %b want 0", cout); end
        launch(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_done(100, lat);
        n_checks++; if (result !== 32'hFFF0_FFF0) begin n_fail++; $display("FAIL or_result got %h want fff0fff0", result); end
        n_checks++; if (cout !== 1'b0 || zero !== 1'b0) begin
            n_fail++; $display("FAIL or_flags got cout=%b zero=%b want 0 0", cout, zero);
        end
    endtask

    task automatic test_slt;
        int lat;
        launch(3'b111, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_done(100, lat);
        n_checks++; if (result !== 32'h1) begin n_fail++; $display("FAIL slt_neg_result got %h want 1", result); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL slt_neg_cout got %b want 0", cout); end
        launch(3'b111, 32'd4, 32'd2);
        wait_done(100, lat);
        n_checks++; if (result !== 32'h0 || zero !== 1'b1) begin
            n_fail++; $display("FAIL slt_pos got result=%h zero=%b want 0 1", result, zero);
        end
    endtask

    task automatic test_illegal;
        int lat;
        launch(3'b011, 32'h1234_5678, 32'h1111_1111);
        wait_done(100, lat);
        n_checks++; if (lat !== 1)        begin n_fail++; $display("FAIL ill_latency got %0d want 1", lat); end
        n_checks++; if (err !== 1'b1)     begin n_fail++; $display("FAIL ill_err got %b want 1", err); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL ill_result got %h want 0", result); end
        n_checks++; if (zero !== 1'b1 || cout !== 1'b0) begin
            n_fail++; $display("FAIL ill_flags got zero=%b cout=%b want 1 0", zero, cout);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        int rest;
        launch(3'b010, 32'd10, 32'd20);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ign_err_clear got %b want 0", err); end
        repeat (10) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1 || result !== 32'h0) begin
            n_fail++; $display("FAIL ign_hold got busy=%b result=%h want 1 00000000", busy, result);
        end
        @(negedge clk);
        op = 3'b110; a = '0; b = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 11;
        wait_done(100, rest);
        lat += rest;
        n_checks++; if (lat !== 33)        begin n_fail++; $display("FAIL ign_latency got %0d want 33", lat); end
        n_checks++; if (result !== 32'd30) begin n_fail++; $display("FAIL ign_result got %h want 0000001e", result); end
    endtask

    task automatic test_back_to_back;
        launch(3'b010, 32'd1, 32'd1);
        repeat (32) begin @(posedge clk); #1; end
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_pre got done=%b busy=%b want 0 1", done, busy);
        end
        @(negedge clk);
        op = 3'b000; a = '0; b = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || result !== 32'd2) begin
            n_fail++; $display("FAIL b2b_done got done=%b result=%h want 1 00000002", done, result);
        end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ignored got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int seen = 0;
        launch(3'b010, 32'd100, 32'd200);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_done got %0d pulses want 0", seen); end
        launch(3'b010, 32'd2, 32'd3);
        wait_done(100, lat);
        n_checks++; if (lat !== 33 || result !== 32'd5) begin
            n_fail++; $display("FAIL rst_next_add got lat=%0d result=%h want 33 00000005", lat, result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_slt();
        test_illegal();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
